widen_check_collector: RTL

Pipelined checker that sits directly downstream of the signed/unsigned port-and-net test stage. It consumes each narrow value together with its one-bit-wider copy and the declared signedness. It recomputes the expected widening (sign- or zero-extension), compares, and emits a per-sample pass/fail result with a tag. It also keeps running totals for the end-of-run summary.

---
 rtl/widen_check_collector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/widen_check_collector.sv
// widen_check_collector: two-stage checker for widened values.
// S1 captures each accepted sample; S2 recomputes the expected sign- or
// zero-extension of the narrow value, compares it with the supplied wide
// value, and holds the result until it is consumed. Running totals, fail
// counts and the tag of the first failure are kept for the end-of-run summary.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             zero counters and first-fail capture (pipeline untouched)
//   in_valid/in_ready sample handshake; in_data, in_wide, in_signed, in_tag
//   out_valid/out_ready result handshake; out_tag, out_pass, out_expected
//   total_cnt, fail_cnt               saturating result counters
//   first_fail_vld, first_fail_tag    first consumed failure
module widen_check_collector #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = IN_W + 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [OUT_W-1:0] in_wide,
    input  logic             in_signed,
    input  logic [3:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_tag,
    output logic             out_pass,
    output logic [OUT_W-1:0] out_expected,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [3:0]       first_fail_tag
);

    localparam int unsigned EXT_W = OUT_W - IN_W;
    localparam int unsigned TAG_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // S1 capture registers
    logic             s1_v;
    logic [IN_W-1:0]  s1_data;
    logic [OUT_W-1:0] s1_wide;
    logic             s1_signed;
    logic [TAG_W-1:0] s1_tag;

    // Handshake qualifiers
    logic out_fire_c;
    logic s2_can_load_c;
    logic s1_accept_c;
    logic s2_load_c;

    // Expected widening and compare, evaluated on S1 contents
    logic             ext_bit_c;
    logic [OUT_W-1:0] expected_c;
    logic             pass_c;

    assign out_fire_c    = out_valid && out_ready;
    assign s2_can_load_c = !out_valid || out_ready;
    // Deliberately combinational from out_ready so a draining S2 frees S1 in the same cycle
    assign in_ready      = !s1_v || s2_can_load_c;
    assign s1_accept_c   = in_valid && in_ready;
    assign s2_load_c     = s1_v && s2_can_load_c;

    assign ext_bit_c  = s1_signed & s1_data[IN_W-1];
    assign expected_c = {{EXT_W{ext_bit_c}}, s1_data};
    assign pass_c     = (expected_c == s1_wide);

    // S1: payload written only on acceptance so idle X inputs never get stored
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_data   <= '0;
            s1_wide   <= '0;
            s1_signed <= 1'b0;
            s1_tag    <= '0;
        end else begin
            if (s1_accept_c) begin
                s1_v      <= 1'b1;
                s1_data   <= in_data;
                s1_wide   <= in_wide;
                s1_signed <= in_signed;
                s1_tag    <= in_tag;
            end else if (s2_load_c) begin
                s1_v <= 1'b0;
            end
        end
    end

    // S2: result registers drive out_* directly
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_tag      <= '0;
            out_pass     <= 1'b0;
            out_expected <= '0;
        end else begin
            if (s2_load_c) begin
                out_valid    <= 1'b1;
                out_tag      <= s1_tag;
                out_pass     <= pass_c;
                out_expected <= expected_c;
            end else if (out_fire_c) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Summary counters; clear wins over a simultaneous handshake
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            total_cnt      <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_tag <= '0;
        end else if (out_fire_c) begin
            if (total_cnt != CNT_MAX) begin
                total_cnt <= total_cnt + CNT_W'(1);
            end
            if (!out_pass) begin
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
                if (!first_fail_vld) begin
                    first_fail_vld <= 1'b1;
                    first_fail_tag <= out_tag;
                end
            end
        end
    end

endmodule
